// File: rtl/alu_hs_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode constants and handshake FSM state encoding for alu_hs_seq.
// Revision : 1.0
// ============================================================================
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_hs_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_hs_seq_if
// Brief    : Operand/result handshake bundle between sender, ALU and writeback.
// Revision : 1.0
// ============================================================================
interface alu_hs_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] hi;
   logic             c;
   logic             z;
   logic             n;
   logic             v;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, out, hi, c, z, n, v
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, out, hi, c, z, n, v
   );
endinterface
`default_nettype wire

// File: rtl/alu_hs_seq_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul
// Brief    : WIDTH-cycle unsigned shift-add multiplier, double-width product.
// Revision : 1.0
// ============================================================================
module seq_mul #(
   parameter int WIDTH = 8
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               i_start,
   input  wire logic [WIDTH-1:0]   i_a,
   input  wire logic [WIDTH-1:0]   i_b,
   output logic                    o_done,
   output logic [2*WIDTH-1:0]      o_product
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] c_LAST = SHW'(WIDTH - 1);

   logic               r_busy;
   logic [SHW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] w_acc_next;

   // The product is taken from the adder output so the last step lands in the
   // caller's result registers on the same edge rather than one cycle later.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_done     = r_busy && (r_cnt == c_LAST);
   assign o_product  = w_acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (o_done) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/alu_hs_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_hs_seq
// Brief    : Registered WIDTH-bit ALU with valid/ready handshakes and multi-cycle MUL.
// Revision : 1.0
// ============================================================================
module alu_hs_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic    clk,
   input  wire logic    rst,
   alu_hs_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_state_next;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_product;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH:0]     w_shl;
   logic [SHW-1:0]     w_shamt;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out;
   logic [WIDTH-1:0]   r_hi;
   logic               r_c, r_z, r_n, r_v;

   assign w_is_mul = (bus.sel == OP_MUL);
   assign w_accept = bus.in_valid && w_in_ready;

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = !r_out_valid || bus.out_ready;
            if (w_accept && w_is_mul)
               w_state_next = ST_MUL_BUSY;
         end
         ST_MUL_BUSY: begin
            if (w_mul_done)
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_accept && w_is_mul),
      .i_a       (bus.a),
      .i_b       (bus.b),
      .o_done    (w_mul_done),
      .o_product (w_product)
   );

   // The extra top bit of the shift result holds the last bit shifted out.
   assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
   assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
   assign w_shamt = bus.b[SHW-1:0];
   assign w_shl   = {1'b0, bus.a} << w_shamt;

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (bus.sel)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  w_res = bus.a & bus.b;
         OP_OR:   w_res = bus.a | bus.b;
         OP_XOR:  w_res = bus.a ^ bus.b;
         OP_NOT:  w_res = ~bus.a;
         OP_SHL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_hi        <= '0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
         r_v         <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
         r_out_valid <= 1'b1;
         r_out       <= w_res;
         r_hi        <= '0;
         r_c         <= w_c;
         r_z         <= (w_res == '0);
         r_n         <= w_res[WIDTH-1];
         r_v         <= w_v;
      end else if (w_mul_done) begin
         r_out_valid <= 1'b1;
         r_out       <= w_product[WIDTH-1:0];
         r_hi        <= w_product[2*WIDTH-1:WIDTH];
         r_c         <= |w_product[2*WIDTH-1:WIDTH];
         r_z         <= (w_product[WIDTH-1:0] == '0);
         r_n         <= w_product[WIDTH-1];
         r_v         <= 1'b0;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.hi        = r_hi;
   assign bus.c         = r_c;
   assign bus.z         = r_z;
   assign bus.n         = r_n;
   assign bus.v         = r_v;
endmodule
`default_nettype wire
